step_dir_monitor: RTL and testbench

STEP_DIR_MONITOR -- requirements
Module: step_dir_monitor

---
 rtl/motor_pkg.sv | 27 ++
 rtl/step_dir_monitor_chk.sv | 18 +
 rtl/sync_edge_det.sv | 47 ++++
 rtl/step_dir_monitor.sv | 196 +++++++++++++++++++
 tb/tb_step_dir_monitor.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/motor_pkg.sv
// Shared widths, FSM state encoding and small helpers for the step/dir monitor.
package motor_pkg;

  localparam int POS_W = 19;
  localparam int DIV_W = 15;

  localparam logic [DIV_W-1:0] GAP_MAX = 15'h7FFF;
  localparam logic [DIV_W-1:0] GAP_ONE = 15'h0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } mon_state_e;

  // A zero divider selects the longest representable timeout.
  function automatic logic [DIV_W-1:0] eff_timeout(input logic [DIV_W-1:0] div);
    logic [DIV_W-1:0] res;
    if (div == {DIV_W{1'b0}}) begin
      res = GAP_MAX;
    end else begin
      res = div;
    end
    return res;
  endfunction

endpackage

// File: rtl/step_dir_monitor_chk.sv
// Structural invariants of the step/dir monitor outputs and FSM encoding.
module step_dir_monitor_chk (
  input logic       clk_i,
  input logic       rst_i,
  input logic       valid_i,
  input logic       moving_i,
  input logic [1:0] state_i
);

  a_valid_implies_moving: assert property (
    @(posedge clk_i) disable iff (rst_i) valid_i |-> moving_i
  );

  a_state_legal: assert property (
    @(posedge clk_i) disable iff (rst_i) state_i != 2'b11
  );

endmodule

// File: rtl/sync_edge_det.sv
// Multi-stage input synchronizer with an edge detector on the synchronized level.
module sync_edge_det #(
  parameter int STAGES    = 2,
  parameter bit RISE_ONLY = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic edge_o
);

  localparam int STG = (STAGES < 2) ? 2 : STAGES;

  logic [STG-1:0] sync_q;
  logic           prev_q;
  logic [STG:0]   vld_q;

  // Synchronizer chain, previous-level register and pipeline-fill tracker.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STG{1'b0}};
      prev_q <= 1'b0;
      vld_q  <= {(STG + 1){1'b0}};
    end else begin
      sync_q <= {sync_q[STG-2:0], async_i};
      prev_q <= sync_q[STG-1];
      vld_q  <= {vld_q[STG-1:0], 1'b1};
    end
  end

  assign sync_o = sync_q[STG-1];

  // Edges are suppressed until both the level and its predecessor hold real
  // samples, so a line already high at reset release never looks like a rise.
  always_comb begin
    edge_o = 1'b0;
    if (!vld_q[STG]) begin
      edge_o = 1'b0;
    end else if (RISE_ONLY) begin
      edge_o = sync_q[STG-1] & ~prev_q;
    end else begin
      edge_o = sync_q[STG-1] ^ prev_q;
    end
  end

endmodule

// File: rtl/step_dir_monitor.sv
// Step/direction input monitor: position accumulator, step-period measurement,
// motion detection and direction-setup violation flag.
module step_dir_monitor
  import motor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIR_SETUP   = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             stepIn,
  input  logic             dirIn,
  input  logic             dirInvert,
  input  logic             posLoad,
  input  logic [POS_W-1:0] posLoadVal,
  input  logic [DIV_W-1:0] timeoutDiv,
  input  logic             errClear,
  output logic [POS_W-1:0] position,
  output logic [DIV_W-1:0] stepPeriod,
  output logic             periodValid,
  output logic             moving,
  output logic             dirSetupErr
);

  localparam int AGE_W = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DIR_SETUP);
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic step_rise_s;
  logic step_lvl_s;
  logic step_edge_s;
  logic dir_sync_s;
  logic dir_chg_s;
  logic eff_dir_s;
  logic timeout_s;

  logic [POS_W-1:0] pos_q, pos_d;
  logic [DIV_W-1:0] gap_q, gap_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             moving_q, moving_d;
  logic             err_q, err_d;
  logic [AGE_W-1:0] age_q, age_d;
  mon_state_e       state_q, state_d;

  sync_edge_det #(
    .STAGES   (SYNC_STAGES),
    .RISE_ONLY(1'b1)
  ) u_step_sync (
    .clk_i  (CLK),
    .rst_i  (reset),
    .async_i(stepIn),
    .sync_o (step_lvl_s),
    .edge_o (step_rise_s)
  );

  sync_edge_det #(
    .STAGES   (SYNC_STAGES),
    .RISE_ONLY(1'b0)
  ) u_dir_sync (
    .clk_i  (CLK),
    .rst_i  (reset),
    .async_i(dirIn),
    .sync_o (dir_sync_s),
    .edge_o (dir_chg_s)
  );

  assign step_edge_s = step_rise_s & step_lvl_s;
  assign eff_dir_s   = dir_sync_s ^ dirInvert;
  assign timeout_s   = (gap_q == eff_timeout(timeoutDiv));

  // Position accumulator; a load discards any step edge in the same cycle.
  always_comb begin
    pos_d = pos_q;
    if (posLoad) begin
      pos_d = posLoadVal;
    end else if (step_edge_s) begin
      if (eff_dir_s) begin
        pos_d = pos_q + POS_ONE;
      end else begin
        pos_d = pos_q - POS_ONE;
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Cycles since the last step edge, saturating.
  always_comb begin
    gap_d = gap_q;
    if (step_edge_s) begin
      gap_d = GAP_ONE;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GAP_ONE;
    end else begin
      gap_d = gap_q;
    end
  end

  // Motion FSM; a step edge always beats a coincident timeout.
  always_comb begin
    state_d  = state_q;
    moving_d = moving_q;
    valid_d  = valid_q;
    period_d = period_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (step_edge_s) begin
          state_d  = ST_ARMED;
          moving_d = 1'b1;
        end else begin
          moving_d = 1'b0;
        end
      end
      ST_ARMED, ST_RUN: begin
        if (step_edge_s) begin
          state_d  = ST_RUN;
          period_d = gap_q;
          valid_d  = 1'b1;
          moving_d = 1'b1;
        end else if (timeout_s) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b0;
          moving_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        valid_d  = 1'b0;
        moving_d = 1'b0;
      end
    endcase
  end

  // Direction age and sticky setup-violation flag (set beats clear).
  always_comb begin
    age_d = age_q;
    err_d = err_q;
    if (dir_chg_s) begin
      age_d = {AGE_W{1'b0}};
    end else if (age_q < AGE_MAX) begin
      age_d = age_q + AGE_ONE;
    end else begin
      age_d = age_q;
    end
    if (step_edge_s && (age_q < AGE_MAX)) begin
      err_d = 1'b1;
    end else if (errClear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pos_q    <= {POS_W{1'b0}};
      gap_q    <= {DIV_W{1'b0}};
      period_q <= {DIV_W{1'b0}};
      valid_q  <= 1'b0;
      moving_q <= 1'b0;
      err_q    <= 1'b0;
      age_q    <= AGE_MAX;
      state_q  <= ST_IDLE;
    end else begin
      pos_q    <= pos_d;
      gap_q    <= gap_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      moving_q <= moving_d;
      err_q    <= err_d;
      age_q    <= age_d;
      state_q  <= state_d;
    end
  end

  assign position    = pos_q;
  assign stepPeriod  = period_q;
  assign periodValid = valid_q;
  assign moving      = moving_q;
  assign dirSetupErr = err_q;

  step_dir_monitor_chk u_chk (
    .clk_i   (CLK),
    .rst_i   (reset),
    .valid_i (valid_q),
    .moving_i(moving_q),
    .state_i (state_q)
  );

endmodule

// File: tb/tb_step_dir_monitor.sv
// Scoreboard bench for step_dir_monitor: expected positions are queued as steps
// and loads are driven, and popped whenever the DUT position changes.
module tb_step_dir_monitor;

  localparam int SS = 2;
  localparam int DS = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic        stepIn;
  logic        dirIn;
  logic        dirInvert;
  logic        posLoad;
  logic [18:0] posLoadVal;
  logic [14:0] timeoutDiv;
  logic        errClear;
  logic [18:0] position;
  logic [14:0] stepPeriod;
  logic        periodValid;
  logic        moving;
  logic        dirSetupErr;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [18:0] exp_pos;
  logic [18:0] last_pos;
  logic [18:0] sb_q[$];
  int          rise_k;
  int          fall_k;
  int          pv_bad;

  step_dir_monitor #(
    .SYNC_STAGES(SS),
    .DIR_SETUP  (DS)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .stepIn     (stepIn),
    .dirIn      (dirIn),
    .dirInvert  (dirInvert),
    .posLoad    (posLoad),
    .posLoadVal (posLoadVal),
    .timeoutDiv (timeoutDiv),
    .errClear   (errClear),
    .position   (position),
    .stepPeriod (stepPeriod),
    .periodValid(periodValid),
    .moving     (moving),
    .dirSetupErr(dirSetupErr)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_step();
    if (dirIn ^ dirInvert) exp_pos = exp_pos + 19'd1;
    else exp_pos = exp_pos - 19'd1;
    sb_q.push_back(exp_pos);
  endtask

  task automatic do_step(input int hi, input int lo);
    push_step();
    stepIn = 1'b1;
    repeat (hi) @(negedge CLK);
    stepIn = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic load_pos(input logic [18:0] v);
    posLoad    = 1'b1;
    posLoadVal = v;
    exp_pos    = v;
    sb_q.push_back(v);
    @(negedge CLK);
    posLoad = 1'b0;
  endtask

  // Position monitor: every change must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (reset) begin
      last_pos <= position;
    end else if (position !== last_pos) begin
      if (sb_q.size() > 0) check_val("pos", {13'd0, position}, {13'd0, sb_q.pop_front()});
      else check_val("pos_unexpected", {13'd0, position}, {13'd0, last_pos});
      last_pos <= position;
    end
  end

  initial begin
    reset = 1'b1; stepIn = 1'b0; dirIn = 1'b1; dirInvert = 1'b0;
    posLoad = 1'b0; posLoadVal = 19'd0; timeoutDiv = 15'd0; errClear = 1'b0;
    exp_pos = 19'd0;
    repeat (3) @(negedge CLK);
    check_val("rst_pos", {13'd0, position}, 32'd0);
    check_val("rst_period", {17'd0, stepPeriod}, 32'd0);
    check_val("rst_pv", {31'd0, periodValid}, 32'd0);
    check_val("rst_moving", {31'd0, moving}, 32'd0);
    check_val("rst_err", {31'd0, dirSetupErr}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge CLK);

    // Ten steps, forward, 100-cycle spacing.
    for (int i = 0; i < 10; i++) begin
      push_step();
      stepIn = 1'b1;
      repeat (50) @(negedge CLK);
      check_val("t1_moving", {31'd0, moving}, 32'd1);
      if (i == 0) begin
        check_val("t1_armed_pv", {31'd0, periodValid}, 32'd0);
      end else begin
        check_val("t1_pv", {31'd0, periodValid}, 32'd1);
        check_val("t1_period", {17'd0, stepPeriod}, 32'd100);
      end
      stepIn = 1'b0;
      repeat (50) @(negedge CLK);
    end
    check_val("t1_pos", {13'd0, position}, 32'd10);
    check_val("t1_period_end", {17'd0, stepPeriod}, 32'd100);
    check_val("t1_pv_end", {31'd0, periodValid}, 32'd1);
    check_val("t1_moving_end", {31'd0, moving}, 32'd1);

    // Timeout drops moving/periodValid but stepPeriod holds.
    timeoutDiv = 15'd150;
    repeat (100) @(negedge CLK);
    check_val("t1_to_moving", {31'd0, moving}, 32'd0);
    check_val("t1_to_pv", {31'd0, periodValid}, 32'd0);
    check_val("t1_to_period", {17'd0, stepPeriod}, 32'd100);
    timeoutDiv = 15'd0;

    // Wrap at the signed boundary in both directions.
    load_pos(19'h3FFFF);
    repeat (10) @(negedge CLK);
    dirIn = 1'b1;
    do_step(5, 30);
    check_val("t2_wrap_up", {13'd0, position}, 32'h40000);
    dirIn = 1'b0;
    repeat (20) @(negedge CLK);
    do_step(5, 30);
    check_val("t2_wrap_down", {13'd0, position}, 32'h3FFFF);
    check_val("t2_no_err", {31'd0, dirSetupErr}, 32'd0);

    // Single step then idle timeout of 50 cycles, inverted direction sense.
    timeoutDiv = 15'd50;
    dirInvert = 1'b1;
    do_step(5, 100);
    check_val("t3_idle", {31'd0, moving}, 32'd0);
    push_step();
    stepIn = 1'b1;
    rise_k = 0; fall_k = 0; pv_bad = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge CLK);
      if (k == 10) stepIn = 1'b0;
      if (periodValid) pv_bad++;
      if (moving && rise_k == 0) rise_k = k;
      if (!moving && rise_k != 0 && fall_k == 0) fall_k = k;
    end
    check_val("t3_rise_lat", rise_k, SS + 1);
    check_val("t3_fall_after", fall_k - rise_k, 32'd50);
    check_val("t3_pv_low", pv_bad, 32'd0);

    // Direction change too close to a step, then exactly at the setup limit.
    dirInvert = 1'b0;
    timeoutDiv = 15'd0;
    repeat (10) @(negedge CLK);
    dirIn = 1'b1;
    repeat (2) @(negedge CLK);
    do_step(5, 20);
    check_val("t4_err_set", {31'd0, dirSetupErr}, 32'd1);
    check_val("t4_pos_newdir", {13'd0, position}, {13'd0, exp_pos});
    errClear = 1'b1;
    @(negedge CLK);
    errClear = 1'b0;
    @(negedge CLK);
    check_val("t4_err_clr", {31'd0, dirSetupErr}, 32'd0);
    dirIn = 1'b0;
    repeat (DS + 1) @(negedge CLK);
    do_step(5, 20);
    check_val("t4_age_ok", {31'd0, dirSetupErr}, 32'd0);

    // Load coinciding with the registered step edge wins.
    stepIn = 1'b1;
    repeat (SS) @(negedge CLK);
    posLoad = 1'b1;
    posLoadVal = 19'd500;
    exp_pos = 19'd500;
    sb_q.push_back(19'd500);
    @(negedge CLK);
    posLoad = 1'b0;
    repeat (10) @(negedge CLK);
    check_val("t5_load_wins", {13'd0, position}, 32'd500);

    // Reset with stepIn held high; no count until a fresh rising edge.
    check_val("t6_sb_empty", sb_q.size(), 32'd0);
    @(negedge CLK);
    #2 reset = 1'b1;
    #1;
    check_val("t6_rst_pos", {13'd0, position}, 32'd0);
    check_val("t6_rst_period", {17'd0, stepPeriod}, 32'd0);
    check_val("t6_rst_pv", {31'd0, periodValid}, 32'd0);
    check_val("t6_rst_moving", {31'd0, moving}, 32'd0);
    check_val("t6_rst_err", {31'd0, dirSetupErr}, 32'd0);
    repeat (3) @(negedge CLK);
    #2 reset = 1'b0;
    exp_pos = 19'd0;
    repeat (20) @(negedge CLK);
    check_val("t6_held_pos", {13'd0, position}, 32'd0);
    check_val("t6_held_moving", {31'd0, moving}, 32'd0);
    stepIn = 1'b0;
    repeat (10) @(negedge CLK);
    do_step(5, 20);
    check_val("t6_new_edge", {13'd0, position}, 32'h7FFFF);

    repeat (10) @(negedge CLK);
    check_val("sb_drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
